// File: rtl/instr_fetch_ctrl_pkg.sv
// riscv_fetch_pkg: shared fetch state, entry layout and instruction width.
package riscv_fetch_pkg;
  typedef enum logic {FETCH, HALT} fetch_state_e;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: memory, redirect and IF/ID handshake signals of the fetch controller.
interface instr_fetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO with flush; push+pop together is legal even when full.
module fetch_skid_fifo
  import riscv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem   <= '{default: '0};
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= '0;
    end else if (flush) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding IF/ID through a 2-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters (tied to 0 otherwise).
module instr_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 16,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_ctrl_if.master  bus,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
);
  fetch_state_e state, state_d;
  logic [63:0]  pc;
  logic [64:0]  last_byte;
  logic [1:0]   count;
  logic         bad, pop, push, redirect;
  fetch_entry_t head;
  assign redirect  = bus.redirect_valid;
  // 65-bit sum so a PC near 2^64 cannot wrap into the legal range
  assign last_byte = {1'b0, pc} + 65'd3;
  assign bad       = |pc[1:0] || last_byte >= 65'(IMEM_BYTES);
  assign pop       = bus.if_valid && bus.id_ready;
  assign push      = !redirect && state == FETCH && !bad && (count != 2'd2 || pop);
  assign bus.imem_addr = pc;
  assign bus.if_valid  = count != 2'd0;
  assign bus.if_pc     = bus.if_valid ? head.pc : '0;
  assign bus.if_instr  = bus.if_valid ? head.instr : '0;
  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ('{pc: pc, instr: bus.imem_instr}),
    .head  (head),
    .count (count)
  );
  always_comb begin
    state_d = redirect ? FETCH : (state == FETCH && bad) ? HALT : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect) begin
      pc          <= bus.redirect_pc;
      fetch_fault <= 1'b0;
    end else begin
      if (push) pc <= pc + 64'(INSTR_BYTES);
      if (state == FETCH && bad) fetch_fault <= 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = state == FETCH && count == 2'd2 && !pop;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push && !(&fetch_count)) fetch_count <= fetch_count + 32'd1;
      if (stall && !(&stall_count)) stall_count <= stall_count + 32'd1;
    end
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus random redirect/stall traffic against a queue model.
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_fault;
  logic [31:0] fetch_count, stall_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mem [16] = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
                            8'h9A, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
  logic [95:0] q [$];
  logic [63:0] m_pc;
  bit          m_halt, m_fault;
  logic [63:0] exp_pc [4] = '{64'd0, 64'd4, 64'd8, 64'd12};
  logic [31:0] exp_ins [4] = '{32'h02853483, 32'h009A84B3, 32'h0014849A, 32'h02953423};
  logic [63:0] targets [8] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd6, 64'd16,
                               64'hFFFF_FFFF_FFFF_FFFC, 64'd2};

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic [63:0] a);
    int i;
    if (a > 64'd12) return 32'h0;
    i = int'(a);
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  assign bus.imem_instr = word(bus.imem_addr);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("if_valid", {63'd0, bus.if_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("if_pc", bus.if_pc, q[0][95:32]);
      chk("if_instr", {32'd0, bus.if_instr}, {32'd0, q[0][31:0]});
    end
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, m_fault});
  endtask

  // one clock edge of the reference behaviour
  task automatic model(bit rv, logic [63:0] rpc, bit rdy);
    bit pop, room, illegal;
    pop  = q.size() != 0 && rdy;
    room = q.size() < 2 || pop;
    illegal = (m_pc % 4 != 0) || (m_pc > 64'd12);
    if (rv) begin
      q.delete();
      m_pc = rpc;
      m_fault = 0;
      m_halt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_halt) begin
        if (illegal) begin
          m_halt = 1;
          m_fault = 1;
        end else if (room) begin
          q.push_back({m_pc, word(m_pc)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic step(bit rv, logic [63:0] rpc, bit rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
    #2;
    check_all();
    @(posedge clk);
    model(rv, rpc, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", {63'd0, bus.if_valid}, 64'd0);
    chk("rst_pc", bus.if_pc, 64'd0);
    chk("rst_instr", {32'd0, bus.if_instr}, 64'd0);
    chk("rst_fault", {63'd0, fetch_fault}, 64'd0);
    chk("rst_addr", bus.imem_addr, 64'd0);
    chk("rst_fcnt", {32'd0, fetch_count}, 64'd0);
    chk("rst_scnt", {32'd0, stall_count}, 64'd0);
    q.delete();
    m_pc = 64'd0;
    m_halt = 0;
    m_fault = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_s1();
    for (int k = 0; k < 4; k++) begin
      step(0, 64'd0, 1);
      chk("s1_pc", bus.if_pc, exp_pc[k]);
      chk("s1_instr", {32'd0, bus.if_instr}, {32'd0, exp_ins[k]});
    end
    step(0, 64'd0, 1);
    chk("s1_fault", {63'd0, fetch_fault}, 64'd1);
    chk("s1_drained", {63'd0, bus.if_valid}, 64'd0);
    step(0, 64'd0, 1);
    chk("s1_halt_addr", bus.imem_addr, 64'd16);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    do_reset();
    run_s1();
    // backpressure fills the buffer, then releases
    do_reset();
    step(0, 64'd0, 1);
    for (int k = 0; k < 5; k++) step(0, 64'd0, 0);
    chk("s2_addr_hold", bus.imem_addr, 64'd8);
    chk("s2_pc_hold", bus.if_pc, 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("s2_valid", {63'd0, bus.if_valid}, 64'd1);
      chk("s2_order", bus.if_pc, exp_pc[k]);
      step(0, 64'd0, 1);
    end
    // redirect while full and stalled
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 64'd0, 0);
    step(1, 64'd4, 0);
    chk("s3_flush", {63'd0, bus.if_valid}, 64'd0);
    step(0, 64'd0, 1);
    chk("s3_pc", bus.if_pc, 64'd4);
    chk("s3_instr", {32'd0, bus.if_instr}, 64'h009A84B3);
    // misaligned target, then recovery
    step(1, 64'd6, 1);
    chk("s4_loaded", bus.imem_addr, 64'd6);
    step(0, 64'd0, 1);
    chk("s4_fault", {63'd0, fetch_fault}, 64'd1);
    chk("s4_nopush", {63'd0, bus.if_valid}, 64'd0);
    step(1, 64'd0, 1);
    chk("s4_clear", {63'd0, fetch_fault}, 64'd0);
    step(0, 64'd0, 1);
    chk("s4_pc0", bus.if_pc, 64'd0);
    // pop and redirect together while full
    step(0, 64'd0, 0);
    step(1, 64'd8, 1);
    step(0, 64'd0, 1);
    chk("s5_pc8", bus.if_pc, 64'd8);
    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(7) == 0, targets[$urandom_range(7)], $urandom_range(2) != 0);
    // asynchronous reset mid-stream, then the first sequence again
    do_reset();
    run_s1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
